ad80305_rx_fifo_sched: RTL and testbench
========================================

Name: ad80305_rx_fifo_sched

Overview:
- Read-side scheduler for the AD80305 RX clock-domain-crossing FIFO: 24-bit {Q,I} words, written at i_rx_clk, read at i_fpga_clk_125p.
- Replaces the free-running divide-by-4 read strobe with a controlled sequence:
  - Prefill to a target level before reading.
  - Issue paced read requests.
  - Trim the read pace with watermarks to absorb ppm drift.
  - Recover from underflow/overflow by clearing and refilling the FIFO.
- Sits between the dual-clock FIFO and the downstream IQ consumer in the 125 MHz domain.

Parameters:
- RD_DIV, 4: nominal read period in clocks (125 MHz / 4 = 31.25 MSPS).
- LVL_W, 4: width of the FIFO read-side used-words count.
- FILL_LEVEL, 8: level required before the first read.
- LOW_WM, 4: at or below this level, the next period is stretched to RD_DIV+1.
- HIGH_WM, 12: at or above this level, the next period is shortened to RD_DIV-1.
- ACLR_CYC, 4: number of clocks o_fifo_aclr is held during resync.
- CNT_W, 8: width of the status counters.

Ports:
- i_fpga_clk_125p  in  1  sole clock.
- i_fpga_rst_125p  in  1  reset, asynchronous, active-low.
- i_enable  in  1  run request; level-sensitive.
- i_rdempty  in  1  FIFO read-side empty flag.
- i_rdusedw  in  LVL_W  FIFO read-side level.
- i_wrfull_sync  in  1  FIFO write-full flag, already synchronised to this clock.
- i_clr_cnt  in  1  single-cycle pulse that clears the status counters.
- o_rd_req  out  1  FIFO rdreq, one-cycle pulse.
- o_iqdata_fp  out  1  FIFO q is valid in this cycle.
- o_fifo_aclr  out  1  FIFO asynchronous clear.
- o_locked  out  1  high while the scheduler is in RUN.
- o_state  out  2  state code: IDLE=0, FILL=1, RUN=2, RESYNC=3.
- o_udf_cnt  out  CNT_W  underflow event count, saturating.
- o_ovf_cnt  out  CNT_W  overflow event count, saturating.
- o_slip_cnt  out  CNT_W  period trims (short or long), saturating.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_state = IDLE.
  - o_fifo_aclr = 1.
  - All other outputs = 0.
- IDLE:
  - o_fifo_aclr = 1, o_rd_req = 0.
  - i_enable = 1 → RESYNC.
- RESYNC:
  - o_fifo_aclr = 1 for exactly ACLR_CYC clocks, then → FILL with o_fifo_aclr = 0.
  - i_wrfull_sync is ignored while in RESYNC.
- FILL:
  - When i_rdusedw >= FILL_LEVEL → RUN.
  - On entry to RUN, the phase counter is 0 and the period is RD_DIV.
- RUN:
  - The phase counter counts 0 .. period-1.
  - At the terminal phase with i_rdempty = 0: o_rd_req = 1 in the next cycle.
  - o_iqdata_fp = 1 one cycle after o_rd_req. The FIFO is non-showahead, so read latency is 1.
- Period selection, sampled from i_rdusedw at the terminal phase:
  - Level >= HIGH_WM: next period = RD_DIV-1.
  - Level <= LOW_WM: next period = RD_DIV+1.
  - Otherwise: next period = RD_DIV.
  - o_slip_cnt increments whenever the next period differs from RD_DIV.
- Underflow:
  - Condition: i_rdempty = 1 at the terminal phase.
  - No o_rd_req is issued; o_udf_cnt increments; → RESYNC.
- Overflow:
  - Condition: i_wrfull_sync = 1 in any FILL or RUN cycle.
  - o_ovf_cnt increments; → RESYNC.
- Simultaneous underflow and overflow: both counters increment and a single RESYNC is entered.
- i_enable deasserted in any state other than IDLE:
  - → IDLE on the next clock.
  - A pending o_rd_req is suppressed.
  - An o_iqdata_fp already due for a read that was issued still fires.
- Status counters:
  - All saturate at 2^CNT_W-1.
  - i_clr_cnt zeroes all three and takes priority over a same-cycle increment.
- Pacing limits:
  - o_rd_req never asserts in two consecutive cycles.
  - The minimum spacing between requests is RD_DIV-1.
- Asynchronous reset mid-operation returns every register to its reset value immediately.

Decomposition:
- Shared package ad80305_pkg holds:
  - State encodings (IDLE/FILL/RUN/RESYNC).
  - RD_DIV/LVL_W defaults.
  - The IQ word width of 24.
- One sub-module, ad80305_sat_cnt, is the parameterised saturating counter with clear. It is instantiated three times.
- The FSM, phase counter, and period logic stay in the top-level module.

Test Plan:
- Start-up:
  - Stimulus: reset released, i_enable = 1, model FIFO written at 31.25 MHz.
  - Required response: o_fifo_aclr high for 4 clocks; o_state goes FILL then RUN once the level reaches 8; o_rd_req then pulses every 4 clocks, with o_iqdata_fp one clock later.
- Fast writer:
  - Stimulus: writer at +2% rate.
  - Required response: level reaches 12; at least one 3-clock period observed; o_slip_cnt > 0; o_ovf_cnt stays 0 over 10k reads.
- Underflow:
  - Stimulus: writer halted during RUN.
  - Required response: no o_rd_req while i_rdempty = 1; o_udf_cnt = 1; o_state = RESYNC with 4 clocks of aclr; then FILL.
- Simultaneous events:
  - Stimulus: i_wrfull_sync and an empty terminal phase forced in the same cycle.
  - Required response: both counters step by 1; exactly one RESYNC.
- Saturation and clear:
  - Stimulus: 300 forced underflows, then i_clr_cnt coincident with a further underflow.
  - Required response: o_udf_cnt holds at 255, then reads 0.
- Disable and reset mid-run:
  - Stimulus: i_enable dropped one clock before a terminal phase.
  - Required response: no o_rd_req; IDLE with o_fifo_aclr = 1.
  - Stimulus: asynchronous reset asserted mid-RUN.
  - Required response: outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ad80305_pkg.sv
// Shared definitions for the AD80305 RX FIFO read-side scheduler.
package ad80305_pkg;

    localparam int RD_DIV_DEF = 4;
    localparam int LVL_W_DEF  = 4;
    localparam int IQ_W       = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESYNC = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ad80305_sat_cnt.sv
// Saturating event counter with a synchronous clear that wins over increment.
module ad80305_sat_cnt
    import ad80305_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_fpga_clk_125p,
    input  logic         i_fpga_rst_125p,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count events, stick at all-ones, clear on request.
    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ad80305_rx_fifo_sched.sv
// Read-side scheduler for the AD80305 RX dual-clock FIFO: prefill, paced
// reads with watermark trimming, and clear/refill recovery on under/overflow.
module ad80305_rx_fifo_sched
    import ad80305_pkg::*;
#(
    parameter int RD_DIV     = RD_DIV_DEF,
    parameter int LVL_W      = LVL_W_DEF,
    parameter int FILL_LEVEL = 8,
    parameter int LOW_WM     = 4,
    parameter int HIGH_WM    = 12,
    parameter int ACLR_CYC   = 4,
    parameter int CNT_W      = 8
) (
    input  logic             i_fpga_clk_125p,
    input  logic             i_fpga_rst_125p,
    input  logic             i_enable,
    input  logic             i_rdempty,
    input  logic [LVL_W-1:0] i_rdusedw,
    input  logic             i_wrfull_sync,
    input  logic             i_clr_cnt,
    output logic             o_rd_req,
    output logic             o_iqdata_fp,
    output logic             o_fifo_aclr,
    output logic             o_locked,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_udf_cnt,
    output logic [CNT_W-1:0] o_ovf_cnt,
    output logic [CNT_W-1:0] o_slip_cnt
);

    // Phase counter must hold the stretched period RD_DIV+1.
    localparam int PH_W = $clog2(RD_DIV + 2);
    localparam int AC_W = (ACLR_CYC > 1) ? $clog2(ACLR_CYC) : 1;

    localparam logic [PH_W-1:0]  PER_NOM   = PH_W'(RD_DIV);
    localparam logic [PH_W-1:0]  PER_SHORT = PH_W'(RD_DIV - 1);
    localparam logic [PH_W-1:0]  PER_LONG  = PH_W'(RD_DIV + 1);
    localparam logic [LVL_W-1:0] LVL_FILL  = LVL_W'(FILL_LEVEL);
    localparam logic [LVL_W-1:0] LVL_LOW   = LVL_W'(LOW_WM);
    localparam logic [LVL_W-1:0] LVL_HIGH  = LVL_W'(HIGH_WM);
    localparam logic [AC_W-1:0]  AC_LOAD   = AC_W'(ACLR_CYC - 1);

    sched_state_t    state;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] period;
    logic [AC_W-1:0] aclr_left;
    logic            rd_req_q;
    logic            iq_valid_q;
    logic            aclr_q;
    logic            locked_q;

    logic            terminal;
    logic            ovf_evt;
    logic            udf_evt;
    logic            read_evt;
    logic            slip_evt;
    logic [PH_W-1:0] next_period;

    // Decode this cycle's scheduling events and the watermark-trimmed period.
    always_comb begin
        terminal    = (state == ST_RUN) && (phase == (period - PH_W'(1)));
        ovf_evt     = i_enable && i_wrfull_sync && ((state == ST_FILL) || (state == ST_RUN));
        udf_evt     = i_enable && terminal && i_rdempty;
        read_evt    = i_enable && terminal && !i_rdempty && !i_wrfull_sync;
        next_period = PER_NOM;
        if (i_rdusedw >= LVL_HIGH) begin
            next_period = PER_SHORT;
        end else if (i_rdusedw <= LVL_LOW) begin
            next_period = PER_LONG;
        end
        slip_evt    = read_evt && (next_period != PER_NOM);
    end

    // Scheduler FSM with phase/period tracking and registered strobes.
    always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            state      <= ST_IDLE;
            phase      <= '0;
            period     <= PER_NOM;
            aclr_left  <= '0;
            rd_req_q   <= 1'b0;
            iq_valid_q <= 1'b0;
            aclr_q     <= 1'b1;
            locked_q   <= 1'b0;
        end else begin
            rd_req_q   <= read_evt;
            iq_valid_q <= rd_req_q;
            if (!i_enable) begin
                state    <= ST_IDLE;
                aclr_q   <= 1'b1;
                locked_q <= 1'b0;
                phase    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_RESYNC;
                        aclr_q    <= 1'b1;
                        aclr_left <= AC_LOAD;
                    end
                    ST_RESYNC: begin
                        if (aclr_left == '0) begin
                            state  <= ST_FILL;
                            aclr_q <= 1'b0;
                        end else begin
                            aclr_left <= aclr_left - 1'b1;
                        end
                    end
                    ST_FILL: begin
                        if (ovf_evt) begin
                            state     <= ST_RESYNC;
                            aclr_q    <= 1'b1;
                            aclr_left <= AC_LOAD;
                        end else if (i_rdusedw >= LVL_FILL) begin
                            state    <= ST_RUN;
                            phase    <= '0;
                            period   <= PER_NOM;
                            locked_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (ovf_evt || udf_evt) begin
                            state     <= ST_RESYNC;
                            aclr_q    <= 1'b1;
                            aclr_left <= AC_LOAD;
                            locked_q  <= 1'b0;
                            phase     <= '0;
                        end else if (terminal) begin
                            phase  <= '0;
                            period <= next_period;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_rd_req    = rd_req_q;
    assign o_iqdata_fp = iq_valid_q;
    assign o_fifo_aclr = aclr_q;
    assign o_locked    = locked_q;
    assign o_state     = state;

    ad80305_sat_cnt #(.W(CNT_W)) u_udf_cnt (
        .i_fpga_clk_125p (i_fpga_clk_125p),
        .i_fpga_rst_125p (i_fpga_rst_125p),
        .clr             (i_clr_cnt),
        .inc             (udf_evt),
        .cnt             (o_udf_cnt)
    );

    ad80305_sat_cnt #(.W(CNT_W)) u_ovf_cnt (
        .i_fpga_clk_125p (i_fpga_clk_125p),
        .i_fpga_rst_125p (i_fpga_rst_125p),
        .clr             (i_clr_cnt),
        .inc             (ovf_evt),
        .cnt             (o_ovf_cnt)
    );

    ad80305_sat_cnt #(.W(CNT_W)) u_slip_cnt (
        .i_fpga_clk_125p (i_fpga_clk_125p),
        .i_fpga_rst_125p (i_fpga_rst_125p),
        .clr             (i_clr_cnt),
        .inc             (slip_evt),
        .cnt             (o_slip_cnt)
    );

endmodule

// File: tb/tb_ad80305_rx_fifo_sched.sv
// Self-checking bench for the AD80305 RX FIFO read scheduler.
module tb_ad80305_rx_fifo_sched;
    import ad80305_pkg::*;

    localparam int CNT_W = 8;
    localparam int LVL_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             clr_cnt;
    logic             rdempty;
    logic [LVL_W-1:0] rdusedw;
    logic             wrfull;
    logic             rd_req;
    logic             iq_fp;
    logic             aclr;
    logic             locked;
    logic [1:0]       state;
    logic [CNT_W-1:0] udf_cnt;
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] slip_cnt;

    int checks = 0;
    int errors = 0;

    bit               model_en = 1'b0;
    int               wr_rate  = 0;
    int               model_level = 0;
    int               wr_acc   = 0;
    int               max_lvl  = 0;
    int               emp_err  = 0;
    logic [LVL_W-1:0] man_usedw  = '0;
    logic             man_empty  = 1'b1;
    logic             man_wrfull = 1'b0;

    int   rd_cnt  = 0;
    int   cyc     = 0;
    int   last_rd = -1;
    int   dbl_err = 0;
    int   iq_err  = 0;
    logic prev_rd = 1'b0;
    int   gap_q[$];

    assign rdusedw = model_en ? ((model_level > 15) ? 4'd15 : LVL_W'(model_level)) : man_usedw;
    assign rdempty = model_en ? (model_level == 0) : man_empty;
    assign wrfull  = model_en ? (model_level >= 16) : man_wrfull;

    always #4 clk = ~clk;

    ad80305_rx_fifo_sched dut (
        .i_fpga_clk_125p (clk),
        .i_fpga_rst_125p (rst_n),
        .i_enable        (enable),
        .i_rdempty       (rdempty),
        .i_rdusedw       (rdusedw),
        .i_wrfull_sync   (wrfull),
        .i_clr_cnt       (clr_cnt),
        .o_rd_req        (rd_req),
        .o_iqdata_fp     (iq_fp),
        .o_fifo_aclr     (aclr),
        .o_locked        (locked),
        .o_state         (state),
        .o_udf_cnt       (udf_cnt),
        .o_ovf_cnt       (ovf_cnt),
        .o_slip_cnt      (slip_cnt)
    );

    // Request monitor plus a 16-deep FIFO level model with a fractional-rate writer.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
            last_rd = -1;
        end else begin
            cyc++;
            if (iq_fp !== prev_rd) iq_err++;
            if (rd_req) begin
                if (prev_rd) dbl_err++;
                if (last_rd >= 0) gap_q.push_back(cyc - last_rd);
                last_rd = cyc;
                rd_cnt++;
                if (model_en && model_level == 0) emp_err++;
            end
            prev_rd = rd_req;
        end
        if (model_en) begin
            if (aclr) begin
                model_level = 0;
            end else begin
                if (rd_req && model_level > 0) model_level--;
                wr_acc += wr_rate;
                if (wr_acc >= 1000) begin
                    wr_acc -= 1000;
                    if (model_level < 16) model_level++;
                end
            end
            if (model_level > max_lvl) max_lvl = model_level;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [LVL_W-1:0] usedw, input logic empty, input logic full);
        man_usedw  = usedw;
        man_empty  = empty;
        man_wrfull = full;
    endtask

    task automatic wait_entry(input logic [1:0] target, input int budget, output bit ok);
        int n = 0;
        while (state == target && n < budget) begin
            @(negedge clk);
            n++;
        end
        while (state != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (state == target);
    endtask

    task automatic measure_resync(output int n);
        n = 0;
        while (state == 2'd3 && aclr && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int n;
        int target;
        int min_gap;
        int r0;

        rst_n   = 1'b1;
        enable  = 1'b0;
        clr_cnt = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_state",  state,    0);
        checkOutput("rst_aclr",   aclr,     1);
        checkOutput("rst_rdreq",  rd_req,   0);
        checkOutput("rst_iqfp",   iq_fp,    0);
        checkOutput("rst_locked", locked,   0);
        checkOutput("rst_udf",    udf_cnt,  0);
        checkOutput("rst_ovf",    ovf_cnt,  0);
        checkOutput("rst_slip",   slip_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_hold", state, 0);
        checkOutput("idle_aclr", aclr,  1);

        $display("[TB] start-up with nominal writer");
        enable   = 1'b1;
        wr_rate  = 250;
        model_en = 1'b1;
        wait_entry(2'd3, 20, ok);
        checkOutput("start_resync", ok, 1);
        measure_resync(n);
        checkOutput("start_aclr_len", n, 4);
        checkOutput("start_fill", state, 1);
        checkOutput("start_aclr_low", aclr, 0);
        wait_entry(2'd2, 200, ok);
        checkOutput("start_run", ok, 1);
        checkOutput("start_fill_lvl", (rdusedw >= 4'd8), 1);
        checkOutput("start_locked", locked, 1);
        repeat (40) @(negedge clk);
        checkOutput("start_gap_cnt", (gap_q.size() >= 3), 1);
        if (gap_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) checkOutput("start_gap", gap_q[i], 4);
        end
        checkOutput("start_slip", slip_cnt, 0);
        checkOutput("start_iqfp", iq_err, 0);

        $display("[TB] fast writer");
        wr_rate = 255;
        target  = rd_cnt + 10000;
        n = 0;
        while (rd_cnt < target && n < 60000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fast_reads", (rd_cnt >= target), 1);
        checkOutput("fast_lvl12", (max_lvl >= 12), 1);
        min_gap = 1000;
        foreach (gap_q[i]) if (gap_q[i] < min_gap) min_gap = gap_q[i];
        checkOutput("fast_min_gap", min_gap, 3);
        checkOutput("fast_slip", (slip_cnt > 0), 1);
        checkOutput("fast_ovf", ovf_cnt, 0);
        checkOutput("fast_locked", locked, 1);

        $display("[TB] underflow");
        checkOutput("udf_pre", udf_cnt, 0);
        wr_rate = 0;
        wait_entry(2'd3, 1000, ok);
        checkOutput("udf_resync", ok, 1);
        checkOutput("udf_cnt", udf_cnt, 1);
        checkOutput("udf_no_empty_rd", emp_err, 0);
        checkOutput("udf_unlocked", locked, 0);
        measure_resync(n);
        checkOutput("udf_aclr_len", n, 4);
        checkOutput("udf_fill", state, 1);

        $display("[TB] simultaneous underflow and overflow");
        model_en = 1'b0;
        applyStimulus(4'd8, 1'b0, 1'b0);
        wait_entry(2'd2, 20, ok);
        checkOutput("sim_run", ok, 1);
        repeat (3) @(negedge clk);
        applyStimulus(4'd8, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("sim_udf", udf_cnt, 2);
        checkOutput("sim_ovf", ovf_cnt, 1);
        checkOutput("sim_state", state, 3);
        applyStimulus(4'd0, 1'b1, 1'b1);
        measure_resync(n);
        checkOutput("sim_aclr_len", n, 4);
        applyStimulus(4'd0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("sim_ovf_once", ovf_cnt, 1);
        checkOutput("sim_udf_once", udf_cnt, 2);
        checkOutput("sim_fill", state, 1);

        $display("[TB] saturation and clear");
        applyStimulus(4'd8, 1'b1, 1'b0);
        repeat (2800) @(negedge clk);
        checkOutput("sat_udf", udf_cnt, 255);
        wait_entry(2'd2, 30, ok);
        checkOutput("clr_run", ok, 1);
        repeat (3) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        checkOutput("clr_udf", udf_cnt, 0);
        checkOutput("clr_ovf", ovf_cnt, 0);
        checkOutput("clr_state", state, 3);
        @(negedge clk);
        checkOutput("clr_udf_hold", udf_cnt, 0);

        $display("[TB] disable before terminal phase");
        applyStimulus(4'd8, 1'b0, 1'b0);
        r0 = rd_cnt;
        wait_entry(2'd2, 30, ok);
        checkOutput("dis_run", ok, 1);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("dis_no_rd", rd_cnt - r0, 0);
        checkOutput("dis_state", state, 0);
        checkOutput("dis_aclr", aclr, 1);
        checkOutput("dis_locked", locked, 0);

        $display("[TB] asynchronous reset mid-run");
        enable = 1'b1;
        applyStimulus(4'd13, 1'b0, 1'b0);
        wait_entry(2'd2, 50, ok);
        checkOutput("ar_run", ok, 1);
        repeat (6) @(negedge clk);
        checkOutput("ar_pre_locked", locked, 1);
        checkOutput("ar_pre_slip", (slip_cnt != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_state",  state,    0);
        checkOutput("ar_aclr",   aclr,     1);
        checkOutput("ar_rdreq",  rd_req,   0);
        checkOutput("ar_iqfp",   iq_fp,    0);
        checkOutput("ar_locked", locked,   0);
        checkOutput("ar_slip",   slip_cnt, 0);
        checkOutput("ar_udf",    udf_cnt,  0);
        checkOutput("ar_ovf",    ovf_cnt,  0);
        checkOutput("pace_double", dbl_err, 0);
        checkOutput("pace_iqfp", iq_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
